// File: rtl/job_engine_shell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | job_engine_shell                                                            |
// | Per-kernel adapter: decodes a job descriptor, launches the kernel, watches  |
// | the run with a timeout and holds the completion word until it is accepted.  |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module job_engine_shell #(
   parameter int unsigned HOST_DWIDTH    = 1024,
   parameter int unsigned RETURN_WIDTH   = 41,
   parameter int unsigned PASID_WIDTH    = 9,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    engine_start,
   input  logic [HOST_DWIDTH-1:0]  engine_data,
   output logic                    engine_ready,
   output logic                    complete_ready,
   input  logic                    complete_accept,
   output logic [RETURN_WIDTH-1:0] complete_data,
   output logic                    kern_start,
   output logic                    kern_abort,
   output logic [63:0]             kern_src_addr,
   output logic [63:0]             kern_dst_addr,
   output logic [31:0]             kern_len,
   input  logic                    kern_done,
   input  logic [7:0]              kern_status,
   output logic [31:0]             jobs_done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_RUN   = 2'd2,
      ST_CMPL  = 2'd3
   } state_t;

   localparam logic [7:0] c_STATUS_ZERO_LEN = 8'h01;
   localparam logic [7:0] c_STATUS_TIMEOUT  = 8'hFF;

   state_t r_state;
   state_t w_next;

   logic [23:0]            r_job_tag;
   logic [PASID_WIDTH-1:0] r_pasid;
   logic [7:0]             r_status;
   logic [31:0]            r_counter;
   logic [31:0]            r_kern_len;
   logic [63:0]            r_kern_src;
   logic [63:0]            r_kern_dst;
   logic [31:0]            r_jobs_done;
   logic                   r_engine_ready;
   logic                   r_complete_ready;
   logic                   r_kern_start;
   logic                   r_kern_abort;

   logic [31:0]            w_len;
   logic                   w_take;
   logic                   w_done;
   logic                   w_timeout;
   logic                   w_accept;
   logic                   w_unused_bits;

   assign w_len         = engine_data[95:64];
   assign w_take        = (r_state == ST_IDLE) && engine_start;
   assign w_done        = (r_state == ST_RUN) && kern_done;
   // Done has priority over the timeout when both land on the last RUN cycle.
   assign w_timeout     = (r_state == ST_RUN) && !kern_done && (TIMEOUT_CYCLES != 32'd0) &&
                          (r_counter == (TIMEOUT_CYCLES - 32'd1));
   assign w_accept      = (r_state == ST_CMPL) && complete_accept;
   assign w_unused_bits = ^{engine_data[63:33], engine_data[127:96],
                            engine_data[HOST_DWIDTH-1:256]};

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:  if (engine_start) w_next = (w_len != 32'd0) ? ST_START : ST_CMPL;
         ST_START: w_next = ST_RUN;
         ST_RUN:   if (w_done || w_timeout) w_next = ST_CMPL;
         ST_CMPL:  if (complete_accept) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Handshake outputs are registered copies of the next-state decode.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_engine_ready   <= 1'b1;
         r_complete_ready <= 1'b0;
         r_kern_start     <= 1'b0;
         r_kern_abort     <= 1'b0;
      end else begin
         r_engine_ready   <= (w_next == ST_IDLE);
         r_complete_ready <= (w_next == ST_CMPL);
         r_kern_start     <= (w_next == ST_START);
         r_kern_abort     <= w_timeout;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_job_tag   <= '0;
         r_pasid     <= '0;
         r_status    <= '0;
         r_counter   <= '0;
         r_kern_len  <= '0;
         r_kern_src  <= '0;
         r_kern_dst  <= '0;
         r_jobs_done <= '0;
      end else begin
         if (w_take) begin
            r_job_tag  <= engine_data[23:0];
            r_pasid    <= engine_data[24 +: PASID_WIDTH];
            r_kern_len <= w_len;
            r_kern_src <= engine_data[191:128];
            r_kern_dst <= engine_data[255:192];
            r_status   <= (w_len == 32'd0) ? c_STATUS_ZERO_LEN : 8'h00;
         end
         if (r_state == ST_START)    r_counter <= '0;
         else if (r_state == ST_RUN) r_counter <= r_counter + 32'd1;
         if (w_done)         r_status <= kern_status;
         else if (w_timeout) r_status <= c_STATUS_TIMEOUT;
         if (w_accept) r_jobs_done <= r_jobs_done + 32'd1;
      end
   end

   assign engine_ready   = r_engine_ready;
   assign complete_ready = r_complete_ready;
   assign complete_data  = {r_pasid, r_status, r_job_tag};
   assign kern_start     = r_kern_start;
   assign kern_abort     = r_kern_abort;
   assign kern_src_addr  = r_kern_src;
   assign kern_dst_addr  = r_kern_dst;
   assign kern_len       = r_kern_len;
   assign jobs_done      = r_jobs_done;

endmodule
`default_nettype wire

// File: tb/tb_job_engine_shell.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_job_engine_shell                                                         |
// | Self-checking bench: vector table, hand sequences and randomized jobs.      |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_job_engine_shell;

   localparam int unsigned c_TMO = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          engine_start = 1'b0;
   logic [1023:0] engine_data = '0;
   logic          engine_ready;
   logic          complete_ready;
   logic          complete_accept = 1'b0;
   logic [40:0]   complete_data;
   logic          kern_start;
   logic          kern_abort;
   logic [63:0]   kern_src_addr;
   logic [63:0]   kern_dst_addr;
   logic [31:0]   kern_len;
   logic          kern_done = 1'b0;
   logic [7:0]    kern_status = '0;
   logic [31:0]   jobs_done;

   int            total = 0;
   int            bad = 0;
   logic [31:0]   exp_jobs = '0;

   job_engine_shell #(
      .HOST_DWIDTH   (1024),
      .RETURN_WIDTH  (41),
      .PASID_WIDTH   (9),
      .TIMEOUT_CYCLES(32'd16)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .engine_start   (engine_start),
      .engine_data    (engine_data),
      .engine_ready   (engine_ready),
      .complete_ready (complete_ready),
      .complete_accept(complete_accept),
      .complete_data  (complete_data),
      .kern_start     (kern_start),
      .kern_abort     (kern_abort),
      .kern_src_addr  (kern_src_addr),
      .kern_dst_addr  (kern_dst_addr),
      .kern_len       (kern_len),
      .kern_done      (kern_done),
      .kern_status    (kern_status),
      .jobs_done      (jobs_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] len;
      logic [23:0] tag;
      logic [8:0]  pasid;
      logic [63:0] src;
      logic [63:0] dst;
      int          d;
      logic [7:0]  ks;
      int          wait_n;
      bit          spam;
      logic [7:0]  e_status;
      int          e_cmpl;
      int          e_ks;
      int          e_ab;
   } vec_t;

   vec_t vecs[7];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load_desc(input logic [31:0] len, input logic [23:0] tag, input logic [8:0] pasid,
                            input logic [63:0] src, input logic [63:0] dst);
      for (int w = 0; w < 32; w++) engine_data[w*32 +: 32] = $urandom;
      engine_data[23:0]    = tag;
      engine_data[32:24]   = pasid;
      engine_data[95:64]   = len;
      engine_data[191:128] = src;
      engine_data[255:192] = dst;
   endtask

   // d = cycles after kern_start at which kern_done pulses (0 = never).
   task automatic run_job(input logic [31:0] len, input logic [23:0] tag, input logic [8:0] pasid,
                          input logic [63:0] src, input logic [63:0] dst, input int d,
                          input logic [7:0] ks, input int wait_n, input bit spam,
                          input logic [7:0] e_status, input int e_cmpl, input int e_ks,
                          input int e_ab);
      int          cmpl_n   = 0;
      int          ks_cnt   = 0;
      int          ks_first = 0;
      int          ab_cnt   = 0;
      int          unstable = 0;
      logic [40:0] cd;
      chk("idle_ready", engine_ready, 1);
      load_desc(len, tag, pasid, src, dst);
      engine_start = 1'b1;
      step();
      engine_start = 1'b0;
      chk("ready_low", engine_ready, 0);
      chk("kern_len", kern_len, len);
      chk("kern_src", kern_src_addr, src);
      chk("kern_dst", kern_dst_addr, dst);
      for (int n = 1; n <= 40; n++) begin
         if (kern_start) begin
            ks_cnt++;
            if (ks_first == 0) ks_first = n;
         end
         if (kern_abort) ab_cnt++;
         kern_done   = (d != 0) && (n == d + 1);
         kern_status = kern_done ? ks : 8'($urandom);
         if (complete_ready) begin
            cmpl_n = n;
            break;
         end
         step();
         kern_done = 1'b0;
      end
      chk("cmpl_cycle", cmpl_n, e_cmpl);
      chk("kstart_count", ks_cnt, e_ks);
      if (e_ks != 0) chk("kstart_cycle", ks_first, 1);
      chk("abort_count", ab_cnt, e_ab);
      cd = complete_data;
      chk("cdata", cd, {pasid, e_status, tag});
      for (int i = 0; i < wait_n; i++) begin
         if (spam) begin
            load_desc(32'd5, 24'hDEAD00, 9'h0EE, 64'h9000, 64'hA000);
            engine_start = 1'($urandom);
         end
         step();
         kern_done = 1'b0;
         if (complete_data !== cd || !complete_ready || kern_start || kern_abort ||
             kern_len !== len || kern_src_addr !== src) unstable++;
      end
      engine_start = 1'b0;
      if (wait_n > 0) chk("hold_stable", unstable, 0);
      complete_accept = 1'b1;
      step();
      complete_accept = 1'b0;
      kern_done = 1'b0;
      exp_jobs++;
      chk("cmpl_drop", complete_ready, 0);
      chk("ready_back", engine_ready, 1);
      chk("jobs_done", jobs_done, exp_jobs);
      chk("abort_clear", kern_abort, 0);
   endtask

   initial begin
      vecs[0] = '{32'd4096, 24'hABCDEF, 9'h015, 64'h1000, 64'h2000, 3, 8'h00, 0, 1'b0, 8'h00, 5, 1, 0};
      vecs[1] = '{32'd0, 24'h000001, 9'h003, 64'h5000, 64'h6000, 0, 8'h00, 2, 1'b0, 8'h01, 1, 0, 0};
      vecs[2] = '{32'd64, 24'h123456, 9'h1FF, 64'h11, 64'h22, 0, 8'h00, 0, 1'b0, 8'hFF, 18, 1, 1};
      vecs[3] = '{32'd8, 24'h777777, 9'h0AA, 64'h33, 64'h44, 16, 8'h07, 0, 1'b0, 8'h07, 18, 1, 0};
      vecs[4] = '{32'd12, 24'h0C0C0C, 9'h100, 64'h55, 64'h66, 17, 8'h55, 3, 1'b0, 8'hFF, 18, 1, 1};
      vecs[5] = '{32'd1, 24'h000042, 9'h001, 64'h77, 64'h88, 1, 8'h3C, 0, 1'b0, 8'h3C, 3, 1, 0};
      vecs[6] = '{32'd300, 24'hBEEF01, 9'h0F0, 64'hFFFF_0000_1234_5678, 64'h8765_4321_0000_FFFF,
                  2, 8'h11, 50, 1'b1, 8'h11, 4, 1, 0};

      step();
      step();
      chk("rst_engine_ready", engine_ready, 1);
      chk("rst_complete_ready", complete_ready, 0);
      chk("rst_kern_start", kern_start, 0);
      chk("rst_cdata", complete_data, 0);
      chk("rst_jobs_done", jobs_done, 0);
      rst = 1'b0;
      step();

      foreach (vecs[i])
         run_job(vecs[i].len, vecs[i].tag, vecs[i].pasid, vecs[i].src, vecs[i].dst, vecs[i].d,
                 vecs[i].ks, vecs[i].wait_n, vecs[i].spam, vecs[i].e_status, vecs[i].e_cmpl,
                 vecs[i].e_ks, vecs[i].e_ab);

      // Reset in the middle of a running job.
      load_desc(32'd100, 24'h654321, 9'h0BB, 64'hAB, 64'hCD);
      engine_start = 1'b1;
      step();
      engine_start = 1'b0;
      repeat (5) step();
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_engine_ready", engine_ready, 1);
      chk("mid_rst_complete_ready", complete_ready, 0);
      chk("mid_rst_kern_start", kern_start, 0);
      chk("mid_rst_kern_abort", kern_abort, 0);
      chk("mid_rst_cdata", complete_data, 0);
      chk("mid_rst_kern_len", kern_len, 0);
      chk("mid_rst_kern_src", kern_src_addr, 0);
      chk("mid_rst_kern_dst", kern_dst_addr, 0);
      chk("mid_rst_jobs_done", jobs_done, 0);
      step();
      step();
      chk("mid_rst_no_abort", kern_abort, 0);
      rst = 1'b0;
      exp_jobs = '0;
      step();
      chk("post_rst_no_cmpl", complete_ready, 0);
      run_job(32'd2048, 24'h0A0B0C, 9'h044, 64'h1234, 64'h5678, 4, 8'h00, 0, 1'b0, 8'h00, 6, 1, 0);

      // Counter wrap.
      force dut.r_jobs_done = 32'hFFFF_FFFF;
      step();
      release dut.r_jobs_done;
      exp_jobs = 32'hFFFF_FFFF;
      chk("jobs_preload", jobs_done, 32'hFFFF_FFFF);
      run_job(32'd16, 24'h00BEEF, 9'h002, 64'h10, 64'h20, 2, 8'h00, 0, 1'b0, 8'h00, 4, 1, 0);
      chk("jobs_wrapped", jobs_done, 0);

      // Randomized jobs against a rule-level model.
      for (int r = 0; r < 30; r++) begin
         logic [31:0] len;
         int          d;
         logic [7:0]  ks;
         bit          done_in_time;
         logic [7:0]  e_status;
         int          e_cmpl;
         len = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom);
         d   = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 20));
         ks  = 8'($urandom);
         done_in_time = (d != 0) && (d <= c_TMO);
         if (len == 0) begin
            e_status = 8'h01;
            e_cmpl   = 1;
         end else begin
            e_status = done_in_time ? ks : 8'hFF;
            e_cmpl   = 2 + (done_in_time ? d : int'(c_TMO));
         end
         run_job(len, 24'($urandom), 9'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                 d, ks, int'($urandom_range(0, 3)), 1'b0, e_status, e_cmpl,
                 (len != 0) ? 1 : 0, ((len != 0) && !done_in_time) ? 1 : 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/job_engine_shell.md
# job_engine_shell

Per-kernel adapter sitting directly downstream of the job scheduler's `engine_*` / `complete_*` ports, one instance per kernel slot. It accepts one 1024-bit job descriptor, decodes it, and launches the attached sort kernel with a start pulse. It supervises the run with a timeout, then presents a RETURN_WIDTH completion word and holds it until the scheduler accepts it.

## Interface

**Parameters**
- `HOST_DWIDTH`, 1024: descriptor width.
- `RETURN_WIDTH`, 41: completion word width. Fixed layout `{pasid[8:0], status[7:0], job_tag[23:0]}`.
- `PASID_WIDTH`, 9: PASID field width.
- `TIMEOUT_CYCLES`, 32'd1_000_000: maximum RUN cycles. 0 disables the timeout.

**Ports**
- `clk`  in  1  Sole clock. All logic is on its rising edge.
- `rst`  in  1  Asynchronous, active-high reset.
- `engine_start`  in  1  Descriptor-valid pulse from the scheduler.
- `engine_data`  in  HOST_DWIDTH  Descriptor. Fields:
  - [23:0] job_tag
  - [32:24] pasid
  - [95:64] length in bytes
  - [191:128] source address
  - [255:192] destination address
  - All other bits are ignored.
- `engine_ready`  out  1  Shell is idle and able to take a descriptor.
- `complete_ready`  out  1  Completion word is valid.
- `complete_accept`  in  1  Scheduler consumes the completion word.
- `complete_data`  out  RETURN_WIDTH  Completion word.
- `kern_start`  out  1  One-cycle launch pulse to the kernel.
- `kern_abort`  out  1  One-cycle abort pulse on timeout.
- `kern_src_addr`  out  64  Latched source address.
- `kern_dst_addr`  out  64  Latched destination address.
- `kern_len`  out  32  Latched length.
- `kern_done`  in  1  Kernel finished. One-cycle pulse.
- `kern_status`  in  8  Kernel status, valid while kern_done is high.
- `jobs_done`  out  32  Count of accepted completions. Wraps modulo 2^32.

## Operation

**FSM states:** IDLE, START, RUN, CMPL. Reset state is IDLE.

**IDLE**
- `engine_ready` = 1.
- On `engine_start`, latch job_tag, pasid, length, and both addresses.
  - If length != 0, go to START.
  - If length == 0, set status = 8'h01 and go directly to CMPL. The kernel is not launched.
- `engine_start` while not in IDLE is ignored. Nothing is latched.

**START**
- `kern_start` = 1 for exactly this one cycle.
- Clear the timeout counter.
- Go to RUN.

**RUN**
- The counter increments every cycle.
- On `kern_done`: status = `kern_status`, go to CMPL.
- Else, if TIMEOUT_CYCLES != 0 and counter == TIMEOUT_CYCLES-1: status = 8'hFF, assert `kern_abort` for one cycle (registered), go to CMPL.
- `kern_done` and timeout in the same cycle: done wins, and `kern_abort` is not asserted.

**CMPL**
- `complete_ready` = 1.
- `complete_data` = {pasid, status, job_tag}, held stable until accepted.
- On `complete_accept`: increment `jobs_done` and go to IDLE.

**Other rules**
- `kern_done` outside RUN is ignored.
- `complete_accept` outside CMPL is ignored.
- `kern_*` address and length outputs hold their latched values until the next descriptor is latched.

## Timing

**Reset values.** While `rst` is high, all outputs take these values asynchronously:
- `engine_ready` = 1
- `complete_ready`, `kern_start`, `kern_abort` = 0
- `complete_data`, `kern_src_addr`, `kern_dst_addr`, `kern_len`, `jobs_done` = 0
- Internal status and counter = 0

Asserting `rst` mid-job returns the shell to IDLE with no completion produced and no abort pulse.

**Cycle-level latencies**
- `engine_start` and `engine_ready` both high in cycle T:
  - `engine_ready` = 0 from T+1.
  - `kern_start` = 1 in T+1 only.
  - The kernel outputs are valid from T+1.
- Zero-length descriptor in cycle T: `complete_ready` = 1 from T+1.
- `kern_done` in cycle k: `complete_ready` = 1 from k+1.
- Timeout: RUN lasts at most TIMEOUT_CYCLES cycles, and `kern_abort` and `complete_ready` rise together in the next cycle.
- `complete_ready` and `complete_accept` both high in cycle m:
  - `complete_ready` = 0 from m+1.
  - `engine_ready` = 1 from m+1.
  - `jobs_done` is incremented at m+1.
- Shortest back-to-back sequence: descriptor T, kern_done T+2, accept T+3, next descriptor accepted T+4.
- All outputs are registered. There is no combinational path from any input to any output.

## Test plan

- **Normal job.** Descriptor with tag 24'hABCDEF, pasid 9'h15, len 4096, src 0x1000, dst 0x2000. Kernel returns done with status 8'h00 three cycles after `kern_start`, then accept.
  - `kern_start` is high for one cycle, at T+1.
  - `complete_data` = {9'h15, 8'h00, 24'hABCDEF}.
  - `jobs_done` = 1.
- **Zero length.** Descriptor with len 0 and tag 24'h000001.
  - No `kern_start`.
  - `complete_ready` is high at T+1 with status 8'h01.
- **Timeout.** TIMEOUT_CYCLES = 16 and the kernel never completes.
  - `kern_abort` pulses once, 16 cycles after entering RUN.
  - Status is 8'hFF.
  - A late `kern_done` arriving after the abort is ignored.
- **Done/timeout collision.** `kern_done` with status 8'h07 arrives exactly on the last RUN cycle.
  - Status is 8'h07 and there is no `kern_abort`.
- **Backpressure.** Hold `complete_accept` low for 50 cycles while pulsing `engine_start` with a second descriptor.
  - `complete_data` stays stable throughout.
  - The second descriptor is ignored.
  - `engine_ready` returns one cycle after accept.
- **Reset mid-RUN, then wrap.**
  - Assert `rst` during RUN: all outputs go to their reset values immediately, and the next job completes normally.
  - Preload `jobs_done` to 32'hFFFFFFFF via a force, then run one job: `jobs_done` wraps to 0.
